// File: rtl/definesPkg.sv
// Shared AHB-Lite constants, transfer encodings and slave FSM state for the memory slave.
package definesPkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned HSIZE_WIDTH   = 3;
  localparam int unsigned BURST_SIZE    = 3;
  localparam int unsigned TRANSFER_TYPE = 2;

  localparam logic [TRANSFER_TYPE-1:0] IDLE    = 2'b00;
  localparam logic [TRANSFER_TYPE-1:0] BUSY    = 2'b01;
  localparam logic [TRANSFER_TYPE-1:0] NON_SEQ = 2'b10;
  localparam logic [TRANSFER_TYPE-1:0] SEQ     = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [HSIZE_WIDTH-1:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } slave_state_e;

  // Unknown encodings fall to the default arm, so X behaves like IDLE.
  function automatic logic is_active(input logic [TRANSFER_TYPE-1:0] trans);
    case (trans)
      NON_SEQ, SEQ: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word storage for the AHB memory slave: synchronous write, registered read,
// and write-first forwarding when both ports hit the same word on one edge.
module ahb_mem_array
  import definesPkg::*;
#(
  parameter int unsigned DATA_W = DATA_WIDTH,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IdxW-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IdxW-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// Word-addressed AHB-Lite memory slave with programmable wait states, a read-only
// window and an ERROR response for illegal size, out-of-range or read-only writes.
module ahb_mem_slave
  import definesPkg::*;
#(
  parameter int unsigned ADDR_W      = ADDRESS_WIDTH,
  parameter int unsigned DATA_W      = DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_BASE     = 'hC0,
  parameter int unsigned RO_LIMIT    = 'hFF
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic                     HWRITE,
  input  logic [HSIZE_WIDTH-1:0]   HSIZE,
  input  logic [BURST_SIZE-1:0]    HBURST,
  input  logic [TRANSFER_TYPE-1:0] HTRANS,
  input  logic [DATA_W-1:0]        HWDATA,
  input  logic                     wait_data,
  output logic [DATA_W-1:0]        HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = $clog2(WAIT_STATES + 2) + 1;

  slave_state_e    state_q;
  logic [IdxW-1:0] addr_q;
  logic            write_q;
  logic [CntW-1:0] cnt_q;

  logic            capture;
  logic            in_ro;
  logic            addr_err;
  logic            need_wait;
  logic            go_data;
  logic            wait_done;
  logic [CntW-1:0] cnt_load;
  logic            wr_en;
  logic            rd_en;
  logic [IdxW-1:0] rd_addr;

  // No wrap support, so the burst type carries no information for this slave.
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  // HREADY is high only in IDLE, DATA and ERR2; ERR2 drops the capture since
  // the master must cancel the following transfer after an ERROR.
  assign capture = ((state_q == StIdle) || (state_q == StData)) && is_active(HTRANS);

  assign in_ro    = (HADDR >= ADDR_W'(RO_BASE)) && (HADDR <= ADDR_W'(RO_LIMIT));
  assign addr_err = (HSIZE != HSIZE_WORD) || (HADDR >= ADDR_W'(MEM_DEPTH)) ||
                    (HWRITE && in_ro);

  assign need_wait = (WAIT_STATES != 0) || wait_data;
  assign go_data   = capture && !addr_err && !need_wait;
  assign wait_done = !wait_data && (cnt_q == '0);

  // Remaining WAIT cycles after the first; a wait_data high on the capture edge adds one.
  assign cnt_load = CntW'(WAIT_STATES) + CntW'(wait_data) - CntW'(1);

  assign wr_en   = !HRESET && (state_q == StData) && write_q;
  assign rd_en   = !HRESET && ((go_data && !HWRITE) ||
                               ((state_q == StWait) && wait_done && !write_q));
  assign rd_addr = (state_q == StWait) ? addr_q : HADDR[IdxW-1:0];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      HREADY  <= 1'b1;
      HRESP   <= HRESP_OKAY;
    end else begin
      if (capture) begin
        addr_q  <= HADDR[IdxW-1:0];
        write_q <= HWRITE;
      end
      unique case (state_q)
        StIdle, StData: begin
          if (!capture) begin
            state_q <= StIdle;
            HREADY  <= 1'b1;
            HRESP   <= HRESP_OKAY;
          end else if (addr_err) begin
            state_q <= StErr1;
            HREADY  <= 1'b0;
            HRESP   <= HRESP_ERROR;
          end else if (need_wait) begin
            state_q <= StWait;
            cnt_q   <= cnt_load;
            HREADY  <= 1'b0;
            HRESP   <= HRESP_OKAY;
          end else begin
            state_q <= StData;
            HREADY  <= 1'b1;
            HRESP   <= HRESP_OKAY;
          end
        end
        StWait: begin
          if (wait_done) begin
            state_q <= StData;
            HREADY  <= 1'b1;
            HRESP   <= HRESP_OKAY;
          end else if (!wait_data) begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StErr1: begin
          state_q <= StErr2;
          HREADY  <= 1'b1;
          HRESP   <= HRESP_ERROR;
        end
        StErr2: begin
          state_q <= StIdle;
          HREADY  <= 1'b1;
          HRESP   <= HRESP_OKAY;
        end
        default: begin
          state_q <= StIdle;
          HREADY  <= 1'b1;
          HRESP   <= HRESP_OKAY;
        end
      endcase
    end
  end

  ahb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (wr_en),
    .waddr (addr_q),
    .wdata (HWDATA),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (HRDATA)
  );

  // Hardware decodes an unknown HTRANS as IDLE; simulation flags it.
  htrans_known_a: assert property (@(posedge HCLK) disable iff (HRESET) !$isunknown(HTRANS));

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: a zero-wait instance and a two-wait-state instance
// share one set of master signals; each test drives and checks the instance it targets.
module tb_ahb_mem_slave;
  import definesPkg::*;

  logic        HCLK      = 1'b0;
  logic        HRESET    = 1'b1;
  logic [31:0] HADDR     = '0;
  logic        HWRITE    = 1'b0;
  logic [2:0]  HSIZE     = 3'b010;
  logic [2:0]  HBURST    = '0;
  logic [1:0]  HTRANS    = 2'b00;
  logic [31:0] HWDATA    = '0;
  logic        wait_data = 1'b0;

  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hresp0, hready2, hresp2;

  int checks = 0;
  int passes = 0;

  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .wait_data(wait_data),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );

  ahb_mem_slave #(.WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .wait_data(wait_data),
    .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2)
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a);
    HTRANS = t;
    HWRITE = w;
    HADDR  = a;
    HSIZE  = HSIZE_WORD;
  endtask

  function automatic logic rdy(input bit use2);
    return use2 ? hready2 : hready0;
  endfunction

  // Single non-pipelined transfer; lows counts HREADY-low data-phase cycles (bounded).
  task automatic xfer(input bit use2, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rs,
                      output int lows);
    drive(NON_SEQ, w, a);
    cyc();
    drive(IDLE, 1'b0, 32'h0);
    HWDATA = wd;
    lows = 0;
    while (rdy(use2) !== 1'b1 && lows < 32) begin
      lows++;
      cyc();
    end
    rd = use2 ? hrdata2 : hrdata0;
    rs = use2 ? hresp2 : hresp0;
    cyc();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    drive(IDLE, 1'b0, 32'h0);
    cyc();
    cyc();
    HRESET = 1'b0;
    checks++; if (hready0 !== 1'b1) $display("FAIL rst_hready0: got %b want 1", hready0); else passes++;
    checks++; if (hresp0 !== 1'b0) $display("FAIL rst_hresp0: got %b want 0", hresp0); else passes++;
    checks++; if (hrdata0 !== 32'h0) $display("FAIL rst_hrdata0: got %h want 0", hrdata0); else passes++;
    checks++; if (hready2 !== 1'b1) $display("FAIL rst_hready2: got %b want 1", hready2); else passes++;
    checks++; if (hresp2 !== 1'b0) $display("FAIL rst_hresp2: got %b want 0", hresp2); else passes++;
    checks++; if (hrdata2 !== 32'h0) $display("FAIL rst_hrdata2: got %h want 0", hrdata2); else passes++;
    cyc();
  endtask

  task automatic test_single();
    logic [31:0] rd;
    logic        rs;
    int          lows;
    drive(NON_SEQ, 1'b1, 32'h10);
    cyc();
    HWDATA = 32'hDEADBEEF;
    drive(NON_SEQ, 1'b0, 32'h10);  // pipelined read of the word being written
    checks++; if (hready0 !== 1'b1) $display("FAIL single_wr_ready: got %b want 1", hready0); else passes++;
    cyc();
    drive(IDLE, 1'b0, 32'h0);
    checks++; if ({hready0, hresp0} !== 2'b10) $display("FAIL single_fwd_resp: got %b want 10", {hready0, hresp0}); else passes++;
    checks++; if (hrdata0 !== 32'hDEADBEEF) $display("FAIL single_fwd_rdata: got %h want deadbeef", hrdata0); else passes++;
    cyc();
    checks++; if (hrdata0 !== 32'hDEADBEEF) $display("FAIL single_hold: got %h want deadbeef", hrdata0); else passes++;
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, rs, lows);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL single_rd: got %h want deadbeef", rd); else passes++;
    checks++; if (lows !== 0) $display("FAIL single_lows: got %0d want 0", lows); else passes++;
    checks++; if (rs !== 1'b0) $display("FAIL single_resp: got %b want 0", rs); else passes++;
  endtask

  task automatic test_burst();
    logic [1:0]  tr  [5] = '{SEQ, BUSY, SEQ, SEQ, IDLE};
    logic [31:0] ad  [5] = '{32'h21, 32'h22, 32'h22, 32'h23, 32'h0};
    logic [31:0] exp [5] = '{32'h1, 32'h2, 32'h2, 32'h3, 32'h4};
    HBURST = 3'b011;
    drive(NON_SEQ, 1'b1, 32'h20); cyc();
    HWDATA = 32'h1; drive(SEQ, 1'b1, 32'h21); cyc();
    HWDATA = 32'h2; drive(BUSY, 1'b1, 32'h22); cyc();
    checks++; if ({hready0, hresp0} !== 2'b10) $display("FAIL burst_busy_ready: got %b want 10", {hready0, hresp0}); else passes++;
    HWDATA = 32'hBAD0BAD0; drive(SEQ, 1'b1, 32'h22); cyc();
    HWDATA = 32'h3; drive(SEQ, 1'b1, 32'h23); cyc();
    HWDATA = 32'h4; drive(IDLE, 1'b0, 32'h0); cyc();
    cyc();
    drive(NON_SEQ, 1'b0, 32'h20);
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++; if (hrdata0 !== exp[i]) $display("FAIL burst_rd%0d: got %h want %h", i, hrdata0, exp[i]); else passes++;
      checks++; if (hready0 !== 1'b1) $display("FAIL burst_rdy%0d: got %b want 1", i, hready0); else passes++;
      drive(tr[i], 1'b0, ad[i]);
      cyc();
    end
    HBURST = 3'b000;
  endtask

  task automatic test_ro_write();
    logic [31:0] rd;
    logic        rs;
    int          lows;
    xfer(1'b0, 1'b1, 32'h40, 32'h00001234, rd, rs, lows);
    drive(NON_SEQ, 1'b1, 32'hC4);
    cyc();
    HWDATA = 32'h55;
    drive(IDLE, 1'b0, 32'h0);
    checks++; if ({hready0, hresp0} !== 2'b01) $display("FAIL ro_err1: got %b want 01", {hready0, hresp0}); else passes++;
    cyc();
    checks++; if ({hready0, hresp0} !== 2'b11) $display("FAIL ro_err2: got %b want 11", {hready0, hresp0}); else passes++;
    drive(NON_SEQ, 1'b1, 32'h40);  // offered during ERR2, must not be taken
    cyc();
    drive(IDLE, 1'b0, 32'h0);
    HWDATA = 32'h77;
    checks++; if ({hready0, hresp0} !== 2'b10) $display("FAIL ro_after: got %b want 10", {hready0, hresp0}); else passes++;
    cyc();
    xfer(1'b0, 1'b0, 32'hC4, 32'h0, rd, rs, lows);
    checks++; if (rd === 32'h55) $display("FAIL ro_unchanged: got %h want not 55", rd); else passes++;
    checks++; if (rs !== 1'b0) $display("FAIL ro_read_resp: got %b want 0", rs); else passes++;
    xfer(1'b0, 1'b0, 32'h40, 32'h0, rd, rs, lows);
    checks++; if (rd !== 32'h00001234) $display("FAIL err2_ignored: got %h want 1234", rd); else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] ea [4] = '{32'hC0, 32'hFF, 32'h100, 32'h10};
    logic [2:0]  es [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
    logic        ew [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] rd;
    logic        rs;
    int          lows;
    for (int i = 0; i < 4; i++) begin
      drive(NON_SEQ, ew[i], ea[i]);
      HSIZE = es[i];
      cyc();
      drive(IDLE, 1'b0, 32'h0);
      HWDATA = 32'h55;
      checks++; if ({hready0, hresp0} !== 2'b01) $display("FAIL err%0d_phase1: got %b want 01", i, {hready0, hresp0}); else passes++;
      cyc();
      checks++; if ({hready0, hresp0} !== 2'b11) $display("FAIL err%0d_phase2: got %b want 11", i, {hready0, hresp0}); else passes++;
      cyc();
      checks++; if ({hready0, hresp0} !== 2'b10) $display("FAIL err%0d_idle: got %b want 10", i, {hready0, hresp0}); else passes++;
    end
    xfer(1'b0, 1'b1, 32'hBF, 32'hB0B000BF, rd, rs, lows);
    checks++; if (rs !== 1'b0) $display("FAIL below_ro_wr_resp: got %b want 0", rs); else passes++;
    xfer(1'b0, 1'b0, 32'hBF, 32'h0, rd, rs, lows);
    checks++; if (rd !== 32'hB0B000BF) $display("FAIL below_ro_rd: got %h want b0b000bf", rd); else passes++;
    xfer(1'b0, 1'b0, 32'hFF, 32'h0, rd, rs, lows);
    checks++; if ({rs, lows[0]} !== 2'b00) $display("FAIL last_word_rd: got resp %b lows %0d want 0 0", rs, lows); else passes++;
  endtask

  task automatic test_wait_data();
    drive(NON_SEQ, 1'b0, 32'h10);
    wait_data = 1'b1;
    cyc();
    wait_data = 1'b0;
    drive(IDLE, 1'b0, 32'h0);
    checks++; if ({hready0, hresp0} !== 2'b00) $display("FAIL wd_stall: got %b want 00", {hready0, hresp0}); else passes++;
    cyc();
    checks++; if (hready0 !== 1'b1) $display("FAIL wd_ready: got %b want 1", hready0); else passes++;
    checks++; if (hrdata0 !== 32'hDEADBEEF) $display("FAIL wd_rdata: got %h want deadbeef", hrdata0); else passes++;
    cyc();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        rs;
    int          lows;
    HRESET = 1'b1;
    drive(IDLE, 1'b0, 32'h0);
    cyc();
    HRESET = 1'b0;
    xfer(1'b1, 1'b1, 32'h05, 32'hA5A50005, rd, rs, lows);
    checks++; if (lows !== 2) $display("FAIL ws_write_lows: got %0d want 2", lows); else passes++;
    checks++; if (rs !== 1'b0) $display("FAIL ws_write_resp: got %b want 0", rs); else passes++;
    drive(NON_SEQ, 1'b0, 32'h05);
    cyc();
    drive(IDLE, 1'b0, 32'h0);
    lows = 0;
    while (hready2 !== 1'b1 && lows < 32) begin
      lows++;
      wait_data = (lows == 1);
      cyc();
    end
    wait_data = 1'b0;
    checks++; if (lows !== 3) $display("FAIL ws_read_lows: got %0d want 3", lows); else passes++;
    checks++; if (hresp2 !== 1'b0) $display("FAIL ws_read_resp: got %b want 0", hresp2); else passes++;
    checks++; if (hrdata2 !== 32'hA5A50005) $display("FAIL ws_read_data: got %h want a5a50005", hrdata2); else passes++;
    cyc();
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        rs;
    int          lows;
    xfer(1'b1, 1'b1, 32'h30, 32'h11110030, rd, rs, lows);
    drive(NON_SEQ, 1'b1, 32'h30);
    cyc();
    HWDATA = 32'h22220030;
    drive(IDLE, 1'b0, 32'h0);
    checks++; if (hready2 !== 1'b0) $display("FAIL abort_in_wait: got %b want 0", hready2); else passes++;
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    checks++; if ({hready2, hresp2} !== 2'b10) $display("FAIL abort_ready: got %b want 10", {hready2, hresp2}); else passes++;
    checks++; if (hrdata2 !== 32'h0) $display("FAIL abort_rdata: got %h want 0", hrdata2); else passes++;
    cyc();
    xfer(1'b1, 1'b0, 32'h30, 32'h0, rd, rs, lows);
    checks++; if (rd !== 32'h11110030) $display("FAIL abort_mem: got %h want 11110030", rd); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_ro_write();
    test_errors();
    test_wait_data();
    test_wait_states();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Word-addressed AHB-Lite memory slave.
- Sits directly downstream of the AHB master interface. It drives the interface's Slave modport: consumes HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA and produces HREADY/HRESP/HRDATA.
- Supports single and INCR4/8/16 bursts, BUSY beats, programmable wait states, and an ERROR response for writes to a read-only window or out-of-range addresses.

Parameters:
- ADDR_W, ADDRESS_WIDTH (definesPkg): address bus width.
- DATA_W, DATA_WIDTH (definesPkg): data bus width.
- MEM_DEPTH, 256: number of DATA_W words; word index = HADDR.
- WAIT_STATES, 0: fixed HREADY-low cycles inserted in every OKAY data phase.
- RO_BASE, 'hC0: first word of the read-only window.
- RO_LIMIT, 'hFF: last word of the read-only window (inclusive).

Ports:
- HCLK, input, 1: clock; all logic on the rising edge.
- HRESET, input, 1: reset, synchronous, active-high.
- HADDR, input, ADDR_W: address-phase address.
- HWRITE, input, 1: 1 = write, 0 = read.
- HSIZE, input, HSIZE_WIDTH: transfer size; only 3'b010 (word) is legal.
- HBURST, input, BURST_SIZE: burst type; informational only, no wrap support.
- HTRANS, input, TRANSFER_TYPE: IDLE / BUSY / NON_SEQ / SEQ.
- HWDATA, input, DATA_W: write data, valid in the data phase.
- wait_data, input, 1: when high, extends the current data phase by holding HREADY low.
- HRDATA, output, DATA_W: read data, valid when HREADY=1 in a read data phase.
- HREADY, output, 1: transfer-done / slave-ready.
- HRESP, output, 1: 0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET=1 at a clock edge):
  - HREADY=1, HRESP=0, HRDATA=0, FSM to IDLE.
  - Any pending data phase is dropped; no memory write occurs.
  - Memory contents are not reset.
- Address-phase capture:
  - Occurs on an edge where HREADY=1 and HTRANS is NON_SEQ or SEQ.
  - Registers addr, write, size, and err.
  - err = (HSIZE != 3'b010) | (HADDR >= MEM_DEPTH) | (HWRITE & RO_BASE <= HADDR <= RO_LIMIT).
- IDLE or BUSY in the address phase:
  - No capture and no memory access.
  - The next cycle is zero-wait OKAY (HREADY=1, HRESP=0).
- FSM states:
  - IDLE: no data phase pending. Capture with err=0 → WAIT if (WAIT_STATES>0 or wait_data), else DATA. Capture with err=1 → ERR1.
  - WAIT: HREADY=0, HRESP=0. A counter runs from WAIT_STATES down to 0. Leave for DATA when count==0 and wait_data==0.
  - DATA: HREADY=1, HRESP=0.
    - Write: mem[addr] <= HWDATA at this edge.
    - Read: HRDATA = mem[addr], registered so it is valid throughout the cycle.
    - In the same cycle, a new capture (pipelined burst) re-enters WAIT, DATA, or ERR1 by the rules above; no capture → IDLE.
  - ERR1: HREADY=0, HRESP=1. Always → ERR2.
  - ERR2: HREADY=1, HRESP=1. Memory is not written.
    - A capture in ERR2 is ignored, because the master must cancel after an ERROR.
    - → IDLE.
- Latency:
  - Zero-wait read: data appears one cycle after the address phase.
  - Each wait state adds one cycle; wait_data adds one cycle per high cycle.
- Write→read hazard: a read captured in the same cycle as a write DATA to the same address returns the new HWDATA (forwarding).
- BUSY inside a burst:
  - Does not advance or alter the captured address.
  - The following SEQ is captured normally; the slave performs no burst address checking.
- HRDATA holds its last value outside read DATA cycles.
- Unknown HTRANS (X) is treated as IDLE; the simulation model flags it with an assertion.

Decomposition:
- Shared package definesPkg:
  - Width constants: ADDRESS_WIDTH, DATA_WIDTH, HSIZE_WIDTH, BURST_SIZE, TRANSFER_TYPE.
  - htrans values: IDLE=2'b00, BUSY=2'b01, NON_SEQ=2'b10, SEQ=2'b11.
  - HRESP_OKAY, HRESP_ERROR, HSIZE_WORD.
  - The slave FSM state enum.
- One sub-module, ahb_mem_array:
  - DATA_W x MEM_DEPTH storage.
  - Synchronous write, registered read, write-first forwarding.

Test Plan:
- Reset: HRESET=1 for 2 cycles → HREADY=1, HRESP=0, HRDATA=0 on the first post-reset cycle.
- Single write then read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA=0xDEADBEEF one cycle after the read address phase, HREADY never low.
- INCR4 write then read with 1 BUSY:
  - Write beats 0x20..0x23 = 0x1,0x2,0x3,0x4 with BUSY after beat 2; read them back → 0x1..0x4 in order.
  - The BUSY cycle shows HREADY=1 and no array write.
- Wait states: WAIT_STATES=2, plus wait_data high for 1 cycle during a read of 0x05 → HREADY low for exactly 3 cycles, then data valid with HRESP=0.
- Read-only write: write 0x55 to 0xC4 → ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1); a subsequent read of 0xC4 returns the prior contents unchanged.
- Errors and reset abort:
  - HSIZE=3'b000 → ERROR.
  - HADDR=MEM_DEPTH → ERROR.
  - HRESET asserted during a WAIT cycle of a write to 0x30 → mem[0x30] unchanged, HREADY=1 next cycle.
